hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the 54-instruction MIPS core. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU, computes the result over WIDTH+1 cycles, and holds it in HI/LO. HI/LO are read by MFHI/MFLO, whose value the writeback path returns to the register file. MTHI/MTLO write HI/LO directly.

---
 rtl/hilo_pkg.sv | 14 +
 rtl/hilo_muldiv_core.sv | 68 ++++++
 rtl/hilo_muldiv.sv | 114 +++++++++++
 tb/tb_hilo_muldiv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/hilo_muldiv_core.sv
// Per-step datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] init_lo_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             div_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum, rem_sh, diff;

  // acc holds product-high / partial remainder; sh holds multiplier / dividend-quotient.
  always_comb begin
    sum    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    acc_d  = sum[WIDTH:1];
    sh_d   = {sum[0], sh_q[WIDTH-1:1]};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      div_q  <= div_i;
      opnd_q <= opnd_i;
      acc_q  <= '0;
      sh_q   <= init_lo_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = acc_q;
  assign lo_o   = sh_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO registers with iterative MULT/MULTU/DIV/DIVU; fixed WIDTH+1 edge latency.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             div_q, neg_q, rem_neg_q, div0_q;

  logic             is_signed, is_div, a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             core_last;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] hi_d, lo_d;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign accept    = (state_q == IDLE) && start;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (state_q == RUN),
    .div_i     (is_div),
    .opnd_i    (is_div ? b_mag : a_mag),
    .init_lo_i (is_div ? a_mag : b_mag),
    .last_o    (core_last),
    .hi_o      (core_hi),
    .lo_o      (core_lo)
  );

  // Sign correction applied to the unsigned core result during FIX.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_q) prod = -prod;
    hi_d = prod[2*WIDTH-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (div_q) begin
      lo_d = neg_q ? -core_lo : core_lo;
      hi_d = rem_neg_q ? -core_hi : core_hi;
      if (div0_q) lo_d = DIV0_LO[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            div_q     <= is_div;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= is_div && (b == '0);
          end
        end
        RUN: begin
          if (core_last) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mdl_hi = '0, mdl_lo = '0;
  bit          hold_start = 0;
  int          interf_at  = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0; l = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 4))
        0: return 32'h0;
        1: return 32'h1;
        2: return 32'hFFFF_FFFF;
        3: return 32'h8000_0000;
        default: return 32'h7FFF_FFFF;
      endcase
    end
    return $urandom;
  endfunction

  // Waits from the accept edge for the result, checking timing and the held HI/LO.
  task automatic finish_op(input logic [31:0] eh, input logic [31:0] el,
                           input logic [31:0] ph, input logic [31:0] pl);
    int n;
    bit got;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 32) begin
        check("hold_hi", hi, ph);
        check("hold_lo", lo, pl);
      end
      if (n == interf_at) begin
        start = 1; op = 2'b00; lo_we = 1; wdata = 32'hDEAD_BEEF;
      end else if (interf_at != 0 && n == interf_at + 1) begin
        start = hold_start; lo_we = 0;
      end
      if (done) got = 1;
    end
    check("latency", n, 33);
    check("busy_in_done", busy, 0);
    check("res_hi", hi, eh);
    check("res_lo", lo, el);
    mdl_hi = eh; mdl_lo = el;
    @(posedge clk); #1;
    check("done_one_pulse", done, 0);
    check("busy_next", busy, hold_start);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic weh, input logic wel, input logic [31:0] wd);
    logic [31:0] eh, el;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    hi_we = weh; lo_we = wel; wdata = wd;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 0;
    if (!hold_start) start = 0;
    if (weh) mdl_hi = wd;
    if (wel) mdl_lo = wd;
    check("busy_after_start", busy, 1);
    check("mt_with_start_hi", hi, mdl_hi);
    check("mt_with_start_lo", lo, mdl_lo);
    model(o, x, y, eh, el);
    finish_op(eh, el, mdl_hi, mdl_lo);
  endtask

  task automatic mt_write(input logic weh, input logic wel, input logic [31:0] wd);
    @(negedge clk);
    hi_we = weh; lo_we = wel; wdata = wd;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 0;
    if (weh) mdl_hi = wd;
    if (wel) mdl_lo = wd;
    check("mt_hi", hi, mdl_hi);
    check("mt_lo", lo, mdl_lo);
  endtask

  initial begin
    int dones;
    logic [31:0] eh, el;
    rst = 1; start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk); rst = 0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(2'b11, 32'd7, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0, 0);

    // MTHI preload, then interference during RUN must be ignored.
    mt_write(1, 0, 32'h1234);
    interf_at = 5;
    run_op(2'b11, 32'd100, 32'd7, 0, 0, 0);
    interf_at = 0;

    // Reset mid-operation.
    @(negedge clk);
    start = 1; op = 2'b00; a = 3; b = 4;
    @(posedge clk); #1; start = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    mdl_hi = 0; mdl_lo = 0;
    @(negedge clk); rst = 0;
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check("midrst_no_done", dones, 0);
    run_op(2'b00, 32'd3, 32'd4, 0, 0, 0);

    // Back-to-back: start held through FIX and the done cycle.
    hold_start = 1;
    run_op(2'b01, 32'd6, 32'd9, 0, 0, 0);
    start = 0;
    hold_start = 0;
    model(2'b01, 32'd6, 32'd9, eh, el);
    finish_op(eh, el, mdl_hi, mdl_lo);

    mt_write(1, 1, 32'hA5A5_0F0F);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      logic weh, wel;
      o   = 2'($urandom_range(0, 3));
      weh = ($urandom_range(0, 3) == 0);
      wel = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(o, rnd32(), (o[1] && $urandom_range(0, 7) == 0) ? 32'd0 : rnd32(), weh, wel, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
